// File: rtl/stream_demux_1to4.sv
// rtl/stream_demux_1to4.sv - registered 1-to-4 byte-stream demux with packet lane lock
// Optional per-lane output beat counters are enabled by defining STREAM_DEMUX_STATS_EN.
module stream_demux_1to4 #(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   in_data,
  input  logic [3:0]      in_sel,
  input  logic            in_valid,
  input  logic            in_last,
  output logic            in_ready,
  output logic [4*DW-1:0] out_data,
  output logic [3:0]      out_last,
  output logic [3:0]      out_valid,
  input  logic [3:0]      out_ready,
  output logic            busy,
  output logic [4*CW-1:0] stat_beats
);

  typedef enum logic {S_IDLE = 1'b0, S_PKT = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_lock_lane;
  logic [1:0]    w_lane;
  logic          w_accept;
  logic [DW-1:0] r_data [4];
  logic [3:0]    r_last;
  logic [3:0]    r_valid;
  logic [3:0]    w_drain;
  logic          w_unused_sel;

  assign w_unused_sel = ^in_sel[3:2];
  assign w_drain      = r_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_lock_lane <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_accept && !in_last)
        r_lock_lane <= in_sel[1:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && !in_last) w_state_nxt = S_PKT;
      S_PKT:   if (w_accept && in_last)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Ready depends only on the target lane's occupancy and its consumer, never on in_valid.
  always_comb begin
    w_lane   = (r_state == S_PKT) ? r_lock_lane : in_sel[1:0];
    in_ready = !r_valid[w_lane] || out_ready[w_lane];
    w_accept = in_valid && in_ready;
    busy     = (r_state == S_PKT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_data[i] <= '0;
      r_last  <= 4'd0;
      r_valid <= 4'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_accept && w_lane == 2'(i)) begin
          r_data[i]  <= in_data;
          r_last[i]  <= in_last;
          r_valid[i] <= 1'b1;
        end else if (w_drain[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < 4; i++) out_data[i*DW +: DW] = r_data[i];
    out_last  = r_last;
    out_valid = r_valid;
  end

`ifdef STREAM_DEMUX_STATS_EN
  logic [CW-1:0] r_stat [4];

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_stat[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (w_drain[i] && r_stat[i] != {CW{1'b1}})
          r_stat[i] <= r_stat[i] + CW'(1);
    end
  end

  always_comb begin
    stat_beats = '0;
    for (int i = 0; i < 4; i++) stat_beats[i*CW +: CW] = r_stat[i];
  end
`else
  assign stat_beats = '0;
`endif

endmodule

// File: tb/tb_stream_demux_1to4.sv
// tb/tb_stream_demux_1to4.sv - self-checking bench for stream_demux_1to4
// Per-lane queue model checked every cycle plus directed literal expectations.
module tb_stream_demux_1to4;
  localparam int DW = 8;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   in_data;
  logic [3:0]      in_sel;
  logic            in_valid;
  logic            in_last;
  logic            in_ready;
  logic [4*DW-1:0] out_data;
  logic [3:0]      out_last;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready;
  logic            busy;
  logic [4*CW-1:0] stat_beats;

  stream_demux_1to4 #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .stat_beats(stat_beats)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {logic [DW-1:0] d; logic l;} beat_t;
  beat_t          m_q [4][$];
  logic           m_inpkt;
  logic [1:0]     m_lock;
  int             m_cnt [4];
  logic [DW-1:0]  obs [4][$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [3:0] s, input logic l);
    bit done = 0;
    in_data  = d;
    in_sel   = s;
    in_last  = l;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (in_ready) done = 1;
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Model: each lane is a one-deep queue; compare at negedge, then apply the coming edge.
  initial begin
    logic [3:0]      e_valid;
    logic [1:0]      t;
    logic            e_ready;
    logic [4*CW-1:0] e_stat;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < 4; i++) begin m_q[i].delete(); m_cnt[i] = 0; end
        m_inpkt = 1'b0;
        m_lock  = 2'd0;
      end
      e_valid = 4'd0;
      e_stat  = '0;
      for (int i = 0; i < 4; i++) begin
        e_valid[i] = (m_q[i].size() != 0);
`ifdef STREAM_DEMUX_STATS_EN
        e_stat[i*CW +: CW] = CW'(m_cnt[i]);
`endif
      end
      t       = m_inpkt ? m_lock : in_sel[1:0];
      e_ready = (m_q[t].size() == 0) || out_ready[t];
      chk("m_out_valid", 64'(out_valid), 64'(e_valid));
      chk("m_in_ready", 64'(in_ready), 64'(e_ready));
      chk("m_busy", 64'(busy), 64'(m_inpkt));
      chk("m_stat", 64'(stat_beats), 64'(e_stat));
      for (int i = 0; i < 4; i++) begin
        if (e_valid[i]) begin
          chk("m_out_data", 64'(out_data[i*DW +: DW]), 64'(m_q[i][0].d));
          chk("m_out_last", 64'(out_last[i]), 64'(m_q[i][0].l));
        end
        if (out_valid[i] && out_ready[i]) obs[i].push_back(out_data[i*DW +: DW]);
      end
      if (!rst) begin
        for (int i = 0; i < 4; i++) begin
          if (m_q[i].size() != 0 && out_ready[i]) begin
            void'(m_q[i].pop_front());
            if (m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
          end
        end
        if (in_valid && e_ready) begin
          m_q[t].push_back({in_data, in_last});
          if (!m_inpkt && !in_last) begin
            m_inpkt = 1'b1;
            m_lock  = in_sel[1:0];
          end else if (m_inpkt && in_last) begin
            m_inpkt = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int t0;
    rst = 1'b1; in_data = '0; in_sel = 4'd0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_data", 64'(out_data), 64'd0);
    chk("reset_stat", 64'(stat_beats), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      send(8'hA0 + 8'(i), 4'(i), 1'b1);
      chk("single_valid", 64'(out_valid), 64'(4'b0001 << i));
      chk("single_data", 64'(out_data[i*DW +: DW]), 64'(8'hA0 + 8'(i)));
      chk("single_last", 64'(out_last[i]), 64'd1);
      chk("single_busy", 64'(busy), 64'd0);
    end

    send(8'h5C, 4'hE, 1'b1);
    chk("sel_hi_valid", 64'(out_valid), 64'b0100);
    chk("sel_hi_data", 64'(out_data[2*DW +: DW]), 64'h5C);
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) obs[i].delete();
    out_ready = 4'b1101;
    send(8'h11, 4'd1, 1'b0);
    chk("lock_busy0", 64'(busy), 64'd1);
    chk("lock_stall_ready", 64'(in_ready), 64'd0);
    fork
      begin
        send(8'h22, 4'd3, 1'b0);
        chk("lock_busy1", 64'(busy), 64'd1);
        send(8'h33, 4'd3, 1'b1);
        chk("lock_busy_end", 64'(busy), 64'd0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 4'hF;
      end
    join
    repeat (2) @(posedge clk); #1;
    chk("lock_lane1_count", 64'(obs[1].size()), 64'd3);
    chk("lock_lane3_count", 64'(obs[3].size()), 64'd0);
    if (obs[1].size() == 3) begin
      chk("lock_b0", 64'(obs[1][0]), 64'h11);
      chk("lock_b1", 64'(obs[1][1]), 64'h22);
      chk("lock_b2", 64'(obs[1][2]), 64'h33);
    end

    for (int i = 0; i < 4; i++) obs[i].delete();
    out_ready = 4'b1110;
    send(8'h77, 4'd0, 1'b1);
    t0 = cyc;
    for (int k = 0; k < 5; k++) send(8'hB0 + 8'(k), 4'd2, 1'b1);
    chk("indep_rate", 64'(cyc - t0), 64'd5);
    chk("indep_hold_valid", 64'(out_valid[0]), 64'd1);
    chk("indep_hold_data", 64'(out_data[0 +: DW]), 64'h77);
    out_ready = 4'hF;
    @(posedge clk); #1;
    chk("indep_drained", 64'(out_valid[0]), 64'd0);
    chk("indep_lane0_obs", 64'(obs[0].size()), 64'd1);
    chk("indep_lane2_obs", 64'(obs[2].size()), 64'd5);

    send(8'hD1, 4'd1, 1'b0);
    chk("rstmid_busy", 64'(busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_valid", 64'(out_valid), 64'd0);
    chk("rstmid_busy0", 64'(busy), 64'd0);
    chk("rstmid_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    send(8'hE2, 4'd2, 1'b1);
    chk("rstmid_next_valid", 64'(out_valid), 64'b0100);
    chk("rstmid_next_data", 64'(out_data[2*DW +: DW]), 64'hE2);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 17; k++) begin
      send(8'hC0 + 8'(k), 4'd3, 1'b1);
      if (k == 9) begin
`ifdef STREAM_DEMUX_STATS_EN
        chk("stat_mid", 64'(stat_beats), 64'h9000);
`else
        chk("stat_mid", 64'(stat_beats), 64'h0);
`endif
      end
    end
    repeat (2) @(posedge clk); #1;
`ifdef STREAM_DEMUX_STATS_EN
    chk("stat_sat", 64'(stat_beats), 64'hF000);
`else
    chk("stat_sat", 64'(stat_beats), 64'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
